// File: rtl/mul1_arb_if.sv
// Request/response bundle between the two requesters and the
// shared-multiplier arbiter.
interface mul1_arb_if #(
  parameter int W = 16
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;

  modport slave (
    input  req_valid, a0, b0, a1, b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, a0, b0, a1, b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mul1_arb.sv
// Round-robin two-requester sequencer for the repeated-add
// multiplier datapath; one job in flight at a time.
module mul1_arb #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  mul1_arb_if.slave    bus,
  output logic [W-1:0] d_out,
  output logic         ldA,
  output logic         ldB,
  output logic         clrP,
  output logic         ldP,
  output logic         decB,
  input  logic         eqz,
  input  logic [W-1:0] p_in,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE,
    LDA,
    LDB,
    MUL,
    RSP
  } state_t;

  state_t       state;
  logic         gnt_id;
  logic         ptr;
  logic         win;
  logic [1:0]   req_ready_q;
  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic [W-1:0] rsp_data_q;

  // pointer only matters when both requesters contend
  assign win = (&bus.req_valid) ? ptr : bus.req_valid[1];

  // accumulate strobes must react to eqz in the same cycle
  assign ldP  = (state == MUL) && !eqz;
  assign decB = (state == MUL) && !eqz;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt_id      <= 1'b0;
      ptr         <= 1'b0;
      d_out       <= '0;
      ldA         <= 1'b0;
      ldB         <= 1'b0;
      clrP        <= 1'b0;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      busy        <= 1'b0;
    end else begin
      d_out       <= '0;
      ldA         <= 1'b0;
      ldB         <= 1'b0;
      clrP        <= 1'b0;
      req_ready_q <= 2'b00;
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            state  <= LDA;
            gnt_id <= win;
            d_out  <= win ? bus.a1 : bus.a0;
            ldA    <= 1'b1;
            busy   <= 1'b1;
          end
        end
        LDA: begin
          state       <= LDB;
          d_out       <= gnt_id ? bus.b1 : bus.b0;
          ldB         <= 1'b1;
          clrP        <= 1'b1;
          req_ready_q <= gnt_id ? 2'b10 : 2'b01;
        end
        LDB: begin
          state <= MUL;
        end
        MUL: begin
          if (eqz) begin
            state       <= RSP;
            rsp_data_q  <= p_in;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= gnt_id;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            ptr         <= ~gnt_id;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
